// File: rtl/ipv4_tx.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_tx
// Purpose  : Prepends a 20-byte IPv4 header (no options) to a transport
//            payload stream. The header checksum is precomputed in a
//            dedicated one-cycle CSUM state, after which the 10 header beats
//            are emitted. The payload is then passed straight through with
//            the per-beat byte count derived from the latched payload length.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, nreset          : clock, synchronous active-low reset
//   valid_i, start_i     : transport beat valid / first beat of a packet
//   data_i, len_i        : transport data (byte0 = data_i[7:0]); len_i ignored
//   pl_len_i             : payload length in bytes, sampled with start_i
//   cancel_i             : abort the current packet
//   ready_o              : transport beat consumed (payload phase only)
//   ready_i              : MAC accepts the current beat
//   valid_o, start_o     : MAC beat valid / first header beat
//   data_o, len_o        : MAC data (byte0 = data_o[7:0]) and valid byte count
//   cancel_o             : combinational copy of cancel_i
//   len_err_o            : one-cycle pulse for a payload longer than 65515
// Configuration
//   IPV4_TX_ID_INC_EN    : when defined, the identification field counts
//                          completed packets; otherwise it is fixed at 0.
// ============================================================================
module ipv4_tx #(
  parameter int          DATA_W   = 16,             // only 16 is supported
  parameter logic [31:0] SRC_ADDR = 32'hCEC8_7F80,  // 206.200.127.128
  parameter logic [31:0] DST_ADDR = 32'hCEC8_7F80,  // 206.200.127.128
  parameter logic [7:0]  PROTOCOL = 8'd17,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic              clk,
  input  logic              nreset,
  // transport side
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        len_i,
  input  logic [15:0]       pl_len_i,
  input  logic              cancel_i,
  output logic              ready_o,
  // MAC side
  input  logic              ready_i,
  output logic              valid_o,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        len_o,
  output logic              cancel_o,
  output logic              len_err_o
);

  localparam logic [15:0] MAX_PL_LEN = 16'd65515;  // 65535 - 20 header bytes
  localparam logic [3:0]  LAST_HDR   = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSUM = 2'd1,
    HEAD = 2'd2,
    DATA = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pl_len;
  logic [15:0] tot_len;
  logic [15:0] csum;
  logic [3:0]  beat;
  logic [15:0] byte_cnt;
  logic        len_err;
  logic [15:0] id;

  // len_i is deliberately ignored: the byte count comes from pl_len.
  logic unused_len;
  assign unused_len = &{1'b0, len_i};

  // --------------------------------------------------------------------------
  // Checksum of the header with the checksum word taken as zero.
  // Nine 16-bit words cannot exceed 20 bits; two folds absorb all carries.
  // --------------------------------------------------------------------------
  logic [15:0] tot_len_c;
  logic [19:0] sum_raw;
  logic [16:0] sum_fold1;
  logic [15:0] sum_fold2;

  assign tot_len_c = pl_len + 16'd20;
  assign sum_raw   = 20'h04500 + {4'h0, tot_len_c} + {4'h0, id} + 20'h04000
                   + {4'h0, TTL, PROTOCOL}
                   + {4'h0, SRC_ADDR[31:16]} + {4'h0, SRC_ADDR[15:0]}
                   + {4'h0, DST_ADDR[31:16]} + {4'h0, DST_ADDR[15:0]};
  assign sum_fold1 = {1'b0, sum_raw[15:0]} + {13'h0, sum_raw[19:16]};
  assign sum_fold2 = sum_fold1[15:0] + {15'h0, sum_fold1[16]};

  // --------------------------------------------------------------------------
  // Header word for the current beat, big-endian as it appears on the wire,
  // then byte-swapped so the first wire byte lands in data_o[7:0].
  // --------------------------------------------------------------------------
  logic [15:0] hdr_word;
  logic [15:0] hdr_bus;

  always_comb begin
    hdr_word = 16'h0000;
    case (beat)
      4'd0:    hdr_word = 16'h4500;
      4'd1:    hdr_word = tot_len;
      4'd2:    hdr_word = id;
      4'd3:    hdr_word = 16'h4000;              // DF set, offset 0
      4'd4:    hdr_word = {TTL, PROTOCOL};
      4'd5:    hdr_word = csum;
      4'd6:    hdr_word = SRC_ADDR[31:16];
      4'd7:    hdr_word = SRC_ADDR[15:0];
      4'd8:    hdr_word = DST_ADDR[31:16];
      4'd9:    hdr_word = DST_ADDR[15:0];
      default: hdr_word = 16'h0000;
    endcase
  end

  assign hdr_bus = {hdr_word[7:0], hdr_word[15:8]};

  // --------------------------------------------------------------------------
  // Payload tracking: the beat that brings the count to >= pl_len is last.
  // --------------------------------------------------------------------------
  logic data_fire;
  logic last_beat;
  logic start_ok;
  logic start_bad;

  assign data_fire = valid_i & ready_i;
  assign last_beat = ({1'b0, byte_cnt} + 17'd2) >= {1'b0, pl_len};
  assign start_ok  = valid_i & start_i & (pl_len_i <= MAX_PL_LEN);
  assign start_bad = valid_i & start_i & (pl_len_i >  MAX_PL_LEN);

  // --------------------------------------------------------------------------
  // FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    valid_o  = 1'b0;
    start_o  = 1'b0;
    data_o   = '0;
    len_o    = 2'd0;
    ready_o  = 1'b0;

    case (state)
      IDLE: begin
        // The start beat is left unconsumed; it is the first payload beat.
        if (start_ok) state_nx = CSUM;
      end

      CSUM: state_nx = HEAD;

      HEAD: begin
        valid_o = 1'b1;
        start_o = (beat == 4'd0);
        data_o  = hdr_bus;
        len_o   = 2'd2;
        if (ready_i && (beat == LAST_HDR))
          state_nx = (pl_len != 16'd0) ? DATA : IDLE;
      end

      DATA: begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o  = data_i;
        len_o   = (last_beat && pl_len[0]) ? 2'd1 : 2'd2;
        if (data_fire && last_beat) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase

    if (cancel_i) state_nx = IDLE;
  end

  assign cancel_o  = cancel_i;
  assign len_err_o = len_err;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= IDLE;
      pl_len   <= 16'd0;
      tot_len  <= 16'd0;
      csum     <= 16'd0;
      beat     <= 4'd0;
      byte_cnt <= 16'd0;
      len_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      len_err <= (state == IDLE) & start_bad & ~cancel_i;

      case (state)
        IDLE: begin
          pl_len   <= pl_len_i;
          beat     <= 4'd0;
          byte_cnt <= 16'd0;
        end
        CSUM: begin
          tot_len <= tot_len_c;
          csum    <= ~sum_fold2;
        end
        HEAD: begin
          if (ready_i) beat <= beat + 4'd1;
        end
        DATA: begin
          if (data_fire) byte_cnt <= byte_cnt + 16'd2;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Identification field
  // --------------------------------------------------------------------------
`ifdef IPV4_TX_ID_INC_EN
  logic pkt_done;
  logic [15:0] id_q;

  // A packet counts only when its final beat completes without cancel.
  assign pkt_done = ~cancel_i &
                    (((state == HEAD) & ready_i & (beat == LAST_HDR) & (pl_len == 16'd0)) |
                     ((state == DATA) & data_fire & last_beat));

  always_ff @(posedge clk) begin
    if (!nreset)       id_q <= 16'h0000;
    else if (pkt_done) id_q <= id_q + 16'd1;
  end

  assign id = id_q;
`else
  assign id = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ipv4_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipv4_tx
// Purpose  : Randomised self-checking bench for ipv4_tx. Expected MAC beats
//            are generated from the header byte layout and payload rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipv4_tx;

  localparam logic [31:0] SRC   = 32'hC0A8_0001;  // 192.168.0.1
  localparam logic [31:0] DST   = 32'hC0A8_00C7;  // 192.168.0.199
  localparam logic [7:0]  PROTO = 8'h11;
  localparam logic [7:0]  TTLV  = 8'd64;

  logic        clk = 1'b0;
  logic        nreset;
  logic        valid_i, start_i, cancel_i, ready_i;
  logic [15:0] data_i, pl_len_i;
  logic [1:0]  len_i;
  logic        ready_o, valid_o, start_o, cancel_o, len_err_o;
  logic [15:0] data_o;
  logic [1:0]  len_o;

  always #5 clk = ~clk;

  ipv4_tx #(
    .DATA_W   (16),
    .SRC_ADDR (SRC),
    .DST_ADDR (DST),
    .PROTOCOL (PROTO),
    .TTL      (TTLV)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .valid_i   (valid_i),
    .start_i   (start_i),
    .data_i    (data_i),
    .len_i     (len_i),
    .pl_len_i  (pl_len_i),
    .cancel_i  (cancel_i),
    .ready_o   (ready_o),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .start_o   (start_o),
    .data_o    (data_o),
    .len_o     (len_o),
    .cancel_o  (cancel_o),
    .len_err_o (len_err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Known-good header for pl_len=95, id=0 with the addresses above.
  logic [15:0] gold [10] = '{16'h0045, 16'h7300, 16'h0000, 16'h0040, 16'h1140,
                             16'h61B8, 16'hA8C0, 16'h0100, 16'hA8C0, 16'hC700};

  logic [15:0] exp_w[$];
  logic [1:0]  exp_len[$];
  logic        exp_st[$];
  logic [15:0] pay[$];
  int          exp_id = 0;

  // Reference: lay out the 20 header bytes, checksum them, append payload.
  task automatic build_exp(input int L, input int id, input bit golden);
    logic [7:0]  b [20];
    logic [15:0] tl, idv, cs, w;
    logic [31:0] dst_v, src_v;
    int          sum, n;
    tl = 16'(L + 20);
    idv = 16'(id);
    src_v = SRC;
    dst_v = DST;
    b[0] = 8'h45;      b[1] = 8'h00;     b[2] = tl[15:8];   b[3] = tl[7:0];
    b[4] = idv[15:8];  b[5] = idv[7:0];  b[6] = 8'h40;      b[7] = 8'h00;
    b[8] = TTLV;       b[9] = PROTO;     b[10] = 8'h00;     b[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b[12+i] = src_v[31-8*i -: 8];
      b[16+i] = dst_v[31-8*i -: 8];
    end
    sum = 0;
    for (int i = 0; i < 10; i++) sum += int'({b[2*i], b[2*i+1]});
    while (sum > 32'h0000_FFFF) sum = (sum & 32'hFFFF) + (sum >>> 16);
    cs = ~sum[15:0];
    b[10] = cs[15:8];
    b[11] = cs[7:0];
    exp_w.delete(); exp_len.delete(); exp_st.delete(); pay.delete();
    for (int i = 0; i < 10; i++) begin
      exp_w.push_back(golden ? gold[i] : {b[2*i+1], b[2*i]});
      exp_len.push_back(2'd2);
      exp_st.push_back(i == 0);
    end
    n = (L + 1) / 2;
    for (int j = 0; j < n; j++) begin
      w = 16'($urandom);
      pay.push_back(w);
      exp_w.push_back(w);
      exp_len.push_back((j == n - 1 && (L % 2) == 1) ? 2'd1 : 2'd2);
      exp_st.push_back(1'b0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i = 0; start_i = 0; cancel_i = 0;
      ready_i = 1'($urandom_range(0, 1));
      #1;
      check_eq("idle_valid_o", valid_o, 0);
      check_eq("idle_ready_o", ready_o, 0);
      @(posedge clk); #1;
    end
  endtask

  // rmode: 0 = ready always 1, 1 = toggling, 2 = random.
  task automatic send_pkt(input int L, input int rmode, input int cancel_cyc, input bit golden);
    int total, nsrc, src_idx, out_idx, cyc;
    bit vld, done, canc, in_head, in_data;
    build_exp(L, exp_id, golden);
    total = exp_w.size();
    nsrc = (pay.size() == 0) ? 1 : pay.size();
    src_idx = 0; out_idx = 0; cyc = 0;
    vld = 0; done = 0; canc = 0;
    while (!done) begin
      if (src_idx < nsrc) begin
        if (cyc == 0) vld = 1;
        else if (!vld) vld = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end else vld = 0;
      valid_i  = vld;
      start_i  = vld && (src_idx == 0);
      data_i   = (src_idx < pay.size()) ? pay[src_idx] : 16'h0000;
      len_i    = 2'($urandom);
      pl_len_i = 16'(L);
      cancel_i = (cyc == cancel_cyc);
      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = cyc[0];
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      in_head = (cyc >= 2) && (out_idx < 10);
      in_data = (out_idx >= 10) && (out_idx < total);
      check_eq("valid_o", valid_o, in_head ? 1 : (in_data ? 32'(vld) : 0));
      check_eq("ready_o", ready_o, in_data ? 32'(ready_i) : 0);
      check_eq("cancel_o", cancel_o, cancel_i);
      if (cyc == 1) check_eq("len_err_o", len_err_o, 0);
      if (in_head || (in_data && vld)) begin
        check_eq($sformatf("data_o[%0d]", out_idx), data_o, exp_w[out_idx]);
        check_eq($sformatf("len_o[%0d]", out_idx), len_o, exp_len[out_idx]);
        check_eq($sformatf("start_o[%0d]", out_idx), start_o, exp_st[out_idx]);
      end
      if (cancel_i) begin canc = 1; done = 1; end
      if (in_data && vld && ready_i) begin src_idx++; vld = 0; end
      if (ready_i && (in_head || (in_data && valid_i))) out_idx++;
      if (out_idx == total && !canc) done = 1;
      cyc++;
      if (!done && cyc > 20 * total + 50) begin
        check_eq("timeout", 0, 1);
        done = 1; canc = 1;
      end
      @(posedge clk); #1;
    end
    if (canc) idle_cycles(1);
    else begin
`ifdef IPV4_TX_ID_INC_EN
      exp_id = (exp_id + 1) % 65536;
`endif
    end
  endtask

  task automatic len_err_test();
    valid_i = 1; start_i = 1; pl_len_i = 16'd65516; cancel_i = 0; ready_i = 1;
    #1;
    check_eq("len_err_pre", len_err_o, 0);
    @(posedge clk); #1;
    valid_i = 0; start_i = 0;
    #1;
    check_eq("len_err_pulse", len_err_o, 1);
    check_eq("len_err_valid", valid_o, 0);
    @(posedge clk); #1;
    #1;
    check_eq("len_err_clear", len_err_o, 0);
    check_eq("len_err_valid2", valid_o, 0);
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic reset_mid_test();
    valid_i = 1; start_i = 1; pl_len_i = 16'd10; cancel_i = 0; ready_i = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 4) check_eq("rst_mid_head", valid_o, 1);
      @(posedge clk); #1;
    end
    nreset = 0; valid_i = 0; start_i = 0;
    @(posedge clk); #1;
    nreset = 1;
    #1;
    check_eq("rst_mid_valid", valid_o, 0);
    check_eq("rst_mid_start", start_o, 0);
    check_eq("rst_mid_ready", ready_o, 0);
    check_eq("rst_mid_lenerr", len_err_o, 0);
    exp_id = 0;
    @(posedge clk); #1;
    idle_cycles(2);
  endtask

  initial begin
    nreset = 0; valid_i = 0; start_i = 0; cancel_i = 0; ready_i = 0;
    data_i = 0; len_i = 0; pl_len_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid_o", valid_o, 0);
    check_eq("rst_start_o", start_o, 0);
    check_eq("rst_ready_o", ready_o, 0);
    check_eq("rst_len_err_o", len_err_o, 0);
    nreset = 1;
    @(posedge clk); #1;
    idle_cycles(2);

    send_pkt(95, 0, -1, 1);       // known-good header and 48 data beats
    send_pkt(0, 0, -1, 0);        // header only
    send_pkt(95, 1, -1, 0);       // ready toggling
    send_pkt(7, 0, 6, 0);         // cancel on header beat 4
    send_pkt(3, 0, -1, 0);        // id must not have moved
    len_err_test();
    send_pkt(65515, 0, 12, 0);    // maximal length header, cancel in payload
    send_pkt(1, 2, -1, 0);
    reset_mid_test();
    for (int k = 0; k < 14; k++) begin
      int L, cc;
      L  = $urandom_range(0, 40);
      cc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      send_pkt(L, 2, cc, 0);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
